golomb_rice_bin_decoder: RTL and testbench
==========================================

// Module: golomb_rice_bin_decoder
// PURPOSE
// Decoder counterpart of the golomb_rice_calc rate path. It parses a serial bin stream
// carrying one coeff_abs_level_remaining codeword, using truncated-unary Rice and EGk
// binarization with COEF_REMAIN_BIN_REDUCTION. It returns the symbol, the absolute level
// and the bin count. The RDOQ bench uses it to close the loop: num_bins must equal total_bits.
// PARAMETERS
// COEF_REMAIN_BIN_REDUCTION  3   prefix length that switches from Rice to EGk
// MAX_PREFIX                 24  ones that count as a malformed codeword; keep MAX_PREFIX+1 <= 28
// SYM_W                      32  symbol/abs_level width
// PORTS
// clk         in   1      clock
// rst         in   1      synchronous, active-high reset
// start_dec   in   1      start pulse, sampled in IDLE only
// rice_k      in   3      Rice parameter 0..4, latched at start
// base_level  in   8      baseLevel, latched at start
// bin_valid   in   1      bin available
// bin_val     in   1      bin value
// bin_ready   out  1      decoder accepts a bin; handshake = bin_valid & bin_ready
// dec_done    out  1      1-cycle pulse, results valid
// symbol      out  SYM_W  decoded remaining symbol
// abs_level   out  SYM_W  symbol + base_level
// num_bins    out  8      bins consumed by this codeword
// dec_err     out  1      prefix reached MAX_PREFIX
// BEHAVIOUR
// - Reset: state IDLE. bin_ready, dec_done and dec_err are 0. symbol, abs_level, num_bins and all counters are 0.
// - FSM IDLE->PREFIX->(SUFFIX)->DONE->IDLE. All outputs are registered.
// - IDLE: bin_ready=0. start_dec=1 latches rice_k and base_level, clears pfx, sfx, num_bins and dec_err, and moves to PREFIX.
// - start_dec outside IDLE is ignored. It is neither queued nor allowed to restart decoding.
// - PREFIX: bin_ready=1. Each handshake does num_bins+=1.
//   - bin=1: pfx+=1. If the new pfx equals MAX_PREFIX, set dec_err and go to DONE.
//   - bin=0: slen = (pfx<COEF_REMAIN_BIN_REDUCTION) ? k : pfx-COEF_REMAIN_BIN_REDUCTION+k.
//     If slen==0, go to DONE; otherwise go to SUFFIX.
// - SUFFIX: bin_ready=1. Each handshake does sfx={sfx,bin} (MSB first), num_bins+=1, slen-=1. Go to DONE after the slen==1 handshake.
// - The DONE transition registers the results:
//   - pfx<3: symbol = (pfx<<k) + sfx
//   - else: symbol = (((1<<(pfx-3)) + 2) << k) + sfx
//   - abs_level = symbol + zero-extended base_level. The arithmetic never exceeds 28 bits.
//   - On error: symbol=0, abs_level=0, dec_err=1. num_bins keeps its count.
// - DONE: dec_done=1 for exactly one cycle, bin_ready=0, next state IDLE.
//   - Outputs hold until the next start clears them.
//   - start_dec in DONE is ignored.
// - bin_valid low stalls the FSM with no state change. bin_val is ignored without a handshake.
// - Latency: start at cycle t, PREFIX at t+1. dec_done arrives one cycle after the last handshake; back-to-back bins give t+N+1.
// - rst=1 in any state, including mid-SUFFIX, returns the reset values on the next edge. The partial codeword is discarded.
// TESTING
// 1. k=0, base=3, bins 0 -> symbol 0, abs_level 3, num_bins 1; dec_done at t+2; bin_ready low in IDLE and DONE.
// 2. k=1, base=1, bins 1,1,0,1 -> symbol 5, abs_level 6, num_bins 4.
// 3. k=0, bins 1,1,1,1,0,1 -> symbol 5, num_bins 6 (EGk path; matches golomb_rice_calc total_bits).
// 4. k=2, bins 1,1,1,0,1,0 -> symbol 14, num_bins 6. Repeat case 2 with 3 idle cycles between bins -> same results, dec_done only after the last bin.
// 5. MAX_PREFIX=24, 24 ones -> dec_err=1, symbol 0, abs_level 0, num_bins 24. start_dec pulsed mid-PREFIX -> ignored, result unchanged.
// 6. rst asserted after 2 suffix bins of case 4 -> next cycle IDLE, bin_ready 0, all outputs 0. A fresh case 2 then decodes to 5.

Source files
------------

// File: rtl/golomb_rice_bin_decoder.sv
// Golomb-Rice / EGk bin-stream decoder for one coeff_abs_level_remaining codeword.
// Consumes bins MSB-first over a valid/ready handshake and reports the decoded
// symbol, symbol + base_level, the number of bins consumed and a malformed flag.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_dec         start pulse, honoured in IDLE only
//   rice_k            Rice parameter (0..4), latched at start
//   base_level        baseLevel, latched at start
//   bin_valid/bin_val input bin stream; bin_ready accepts a bin
//   dec_done          one-cycle pulse when results are valid
//   symbol/abs_level  decoded remaining symbol and symbol + base_level
//   num_bins          bins consumed by this codeword
//   dec_err           prefix hit MAX_PREFIX ones
module golomb_rice_bin_decoder #(
  parameter int unsigned COEF_REMAIN_BIN_REDUCTION = 3,
  parameter int unsigned MAX_PREFIX                = 24,
  parameter int unsigned SYM_W                     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_dec,
  input  logic [2:0]       rice_k,
  input  logic [7:0]       base_level,
  input  logic             bin_valid,
  input  logic             bin_val,
  output logic             bin_ready,
  output logic             dec_done,
  output logic [SYM_W-1:0] symbol,
  output logic [SYM_W-1:0] abs_level,
  output logic [7:0]       num_bins,
  output logic             dec_err
);

  // Holds both the prefix count and the suffix length (at most MAX_PREFIX-1-CRBR+4).
  localparam int unsigned CNT_W = $clog2(MAX_PREFIX + 5);
  localparam int unsigned CRBR  = COEF_REMAIN_BIN_REDUCTION;

  typedef enum logic [1:0] {S_IDLE, S_PREFIX, S_SUFFIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         k_q, k_d;
  logic [7:0]         base_q, base_d;
  logic [CNT_W-1:0]   pfx_q, pfx_d;
  logic [CNT_W-1:0]   slen_q, slen_d;
  logic [SYM_W-1:0]   sfx_q, sfx_d;
  logic [SYM_W-1:0]   symbol_q, symbol_d;
  logic [SYM_W-1:0]   abs_level_q, abs_level_d;
  logic [7:0]         num_bins_q, num_bins_d;
  logic               dec_err_q, dec_err_d;
  logic               dec_done_q, dec_done_d;
  logic               bin_ready_q, bin_ready_d;

  logic               hs_c;
  logic [CNT_W-1:0]   pfx_inc_c;
  logic [CNT_W-1:0]   slen_pfx_c;
  logic [SYM_W-1:0]   sfx_shift_c;

  // Rice part below the reduction threshold, EGk base ((1<<(pfx-3))+2) above it.
  function automatic logic [SYM_W-1:0] calc_sym(input logic [CNT_W-1:0] pfx,
                                                input logic [2:0]       k,
                                                input logic [SYM_W-1:0] sfx);
    logic [SYM_W-1:0] hi;
    if (pfx < CNT_W'(CRBR)) hi = SYM_W'(pfx);
    else                    hi = (SYM_W'(1) << (pfx - CNT_W'(CRBR))) + SYM_W'(2);
    return (hi << k) + sfx;
  endfunction

  assign hs_c        = bin_valid & bin_ready_q;
  assign pfx_inc_c   = pfx_q + CNT_W'(1);
  assign slen_pfx_c  = (pfx_q < CNT_W'(CRBR)) ? CNT_W'(k_q)
                                              : pfx_q - CNT_W'(CRBR) + CNT_W'(k_q);
  assign sfx_shift_c = {sfx_q[SYM_W-2:0], bin_val};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_dec) state_d = S_PREFIX;
      S_PREFIX: begin
        if (hs_c) begin
          if (bin_val) begin
            if (pfx_inc_c == CNT_W'(MAX_PREFIX)) state_d = S_DONE;
          end else if (slen_pfx_c == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SUFFIX;
          end
        end
      end
      S_SUFFIX: if (hs_c && slen_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; every output is registered below
  always_comb begin
    k_d         = k_q;
    base_d      = base_q;
    pfx_d       = pfx_q;
    slen_d      = slen_q;
    sfx_d       = sfx_q;
    symbol_d    = symbol_q;
    abs_level_d = abs_level_q;
    num_bins_d  = num_bins_q;
    dec_err_d   = dec_err_q;
    case (state_q)
      S_IDLE: begin
        if (start_dec) begin
          k_d         = rice_k;
          base_d      = base_level;
          pfx_d       = '0;
          slen_d      = '0;
          sfx_d       = '0;
          symbol_d    = '0;
          abs_level_d = '0;
          num_bins_d  = '0;
          dec_err_d   = 1'b0;
        end
      end
      S_PREFIX: begin
        if (hs_c) begin
          num_bins_d = num_bins_q + 8'd1;
          if (bin_val) begin
            pfx_d = pfx_inc_c;
            if (pfx_inc_c == CNT_W'(MAX_PREFIX)) begin
              dec_err_d   = 1'b1;
              symbol_d    = '0;
              abs_level_d = '0;
            end
          end else begin
            slen_d = slen_pfx_c;
            if (slen_pfx_c == '0) begin
              symbol_d    = calc_sym(pfx_q, k_q, '0);
              abs_level_d = calc_sym(pfx_q, k_q, '0) + SYM_W'(base_q);
            end
          end
        end
      end
      S_SUFFIX: begin
        if (hs_c) begin
          num_bins_d = num_bins_q + 8'd1;
          sfx_d      = sfx_shift_c;
          slen_d     = slen_q - CNT_W'(1);
          if (slen_q == CNT_W'(1)) begin
            symbol_d    = calc_sym(pfx_q, k_q, sfx_shift_c);
            abs_level_d = calc_sym(pfx_q, k_q, sfx_shift_c) + SYM_W'(base_q);
          end
        end
      end
      default: ;
    endcase
    bin_ready_d = (state_d == S_PREFIX) || (state_d == S_SUFFIX);
    dec_done_d  = (state_d == S_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q         <= '0;
      base_q      <= '0;
      pfx_q       <= '0;
      slen_q      <= '0;
      sfx_q       <= '0;
      symbol_q    <= '0;
      abs_level_q <= '0;
      num_bins_q  <= '0;
      dec_err_q   <= 1'b0;
      dec_done_q  <= 1'b0;
      bin_ready_q <= 1'b0;
    end else begin
      k_q         <= k_d;
      base_q      <= base_d;
      pfx_q       <= pfx_d;
      slen_q      <= slen_d;
      sfx_q       <= sfx_d;
      symbol_q    <= symbol_d;
      abs_level_q <= abs_level_d;
      num_bins_q  <= num_bins_d;
      dec_err_q   <= dec_err_d;
      dec_done_q  <= dec_done_d;
      bin_ready_q <= bin_ready_d;
    end
  end

  assign bin_ready = bin_ready_q;
  assign dec_done  = dec_done_q;
  assign symbol    = symbol_q;
  assign abs_level = abs_level_q;
  assign num_bins  = num_bins_q;
  assign dec_err   = dec_err_q;

endmodule

// File: tb/tb_golomb_rice_bin_decoder.sv
module tb_golomb_rice_bin_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_dec;
  logic [2:0]  rice_k;
  logic [7:0]  base_level;
  logic        bin_valid;
  logic        bin_val;
  logic        bin_ready;
  logic        dec_done;
  logic [31:0] symbol;
  logic [31:0] abs_level;
  logic [7:0]  num_bins;
  logic        dec_err;

  int n_assert = 0;
  int n_fail   = 0;

  golomb_rice_bin_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .start_dec  (start_dec),
    .rice_k     (rice_k),
    .base_level (base_level),
    .bin_valid  (bin_valid),
    .bin_val    (bin_val),
    .bin_ready  (bin_ready),
    .dec_done   (dec_done),
    .symbol     (symbol),
    .abs_level  (abs_level),
    .num_bins   (num_bins),
    .dec_err    (dec_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start, feed n bins MSB-first from bits with gap idle cycles between bins,
  // then check the dec_done pulse timing and bin_ready around it.
  task automatic decode(input logic [2:0] k, input logic [7:0] base,
                        input logic [31:0] bits, input int n, input int gap);
    rice_k     = k;
    base_level = base;
    start_dec  = 1'b1;
    @(negedge clk);
    start_dec  = 1'b0;
    chk("ready_in_prefix", 32'(bin_ready), 32'd1);
    for (int i = 0; i < n; i++) begin
      bin_valid = 1'b1;
      bin_val   = bits[n-1-i];
      @(negedge clk);
      bin_valid = 1'b0;
      bin_val   = ~bits[n-1-i];
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          chk("no_early_done", 32'(dec_done), 32'd0);
          @(negedge clk);
        end
      end
    end
    chk("done_pulse", 32'(dec_done), 32'd1);
    chk("ready_in_done", 32'(bin_ready), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(dec_done), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start_dec  = 1'b0;
    rice_k     = 3'd0;
    base_level = 8'd0;
    bin_valid  = 1'b0;
    bin_val    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bin_ready), 32'd0);
    chk("rst_done", 32'(dec_done), 32'd0);
    chk("rst_err", 32'(dec_err), 32'd0);
    chk("rst_symbol", symbol, 32'd0);
    chk("rst_abs", abs_level, 32'd0);
    chk("rst_bins", 32'(num_bins), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(bin_ready), 32'd0);

    // Case 1: k=0 base=3, single 0 bin -> symbol 0, done two cycles after start
    decode(3'd0, 8'd3, 32'b0, 1, 0);
    chk("c1_symbol", symbol, 32'd0);
    chk("c1_abs", abs_level, 32'd3);
    chk("c1_bins", 32'(num_bins), 32'd1);
    chk("c1_ready_idle", 32'(bin_ready), 32'd0);

    // Case 2: k=1 base=1, 1101 -> pfx 2, sfx 1 -> symbol 5
    decode(3'd1, 8'd1, 32'b1101, 4, 0);
    chk("c2_symbol", symbol, 32'd5);
    chk("c2_abs", abs_level, 32'd6);
    chk("c2_bins", 32'(num_bins), 32'd4);
    chk("c2_err", 32'(dec_err), 32'd0);

    // Case 3: EGk path, k=0 base=2, 111101 -> ((1<<1)+2)+1 = 5
    decode(3'd0, 8'd2, 32'b111101, 6, 0);
    chk("c3_symbol", symbol, 32'd5);
    chk("c3_abs", abs_level, 32'd7);
    chk("c3_bins", 32'(num_bins), 32'd6);

    // Case 4: k=2 base=0, 111010 -> (3<<2)+2 = 14
    decode(3'd2, 8'd0, 32'b111010, 6, 0);
    chk("c4_symbol", symbol, 32'd14);
    chk("c4_abs", abs_level, 32'd14);
    chk("c4_bins", 32'(num_bins), 32'd6);

    // Case 4b: case 2 with 3 idle cycles between bins
    decode(3'd1, 8'd1, 32'b1101, 4, 3);
    chk("c4b_symbol", symbol, 32'd5);
    chk("c4b_abs", abs_level, 32'd6);
    chk("c4b_bins", 32'(num_bins), 32'd4);

    // Results hold in IDLE; start in DONE/IDLE-after tested via hold
    repeat (2) @(negedge clk);
    chk("hold_symbol", symbol, 32'd5);

    // Case 5: 24 ones -> error; a start pulse mid-PREFIX is ignored
    rice_k     = 3'd3;
    base_level = 8'd9;
    start_dec  = 1'b1;
    @(negedge clk);
    start_dec  = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 10) begin
        start_dec = 1'b1;
        rice_k    = 3'd0;
        @(negedge clk);
        start_dec = 1'b0;
        chk("c5_ready_after_start", 32'(bin_ready), 32'd1);
        chk("c5_bins_after_start", 32'(num_bins), 32'd10);
      end
      chk("c5_no_early_done", 32'(dec_done), 32'd0);
      bin_valid = 1'b1;
      bin_val   = 1'b1;
      @(negedge clk);
      bin_valid = 1'b0;
    end
    chk("c5_done", 32'(dec_done), 32'd1);
    chk("c5_err", 32'(dec_err), 32'd1);
    chk("c5_symbol", symbol, 32'd0);
    chk("c5_abs", abs_level, 32'd0);
    chk("c5_bins", 32'(num_bins), 32'd24);
    @(negedge clk);
    chk("c5_done_low", 32'(dec_done), 32'd0);
    chk("c5_err_hold", 32'(dec_err), 32'd1);

    // Case 6: k=4, prefix 1110 (slen 4), two suffix bins, then reset mid-SUFFIX
    rice_k     = 3'd4;
    base_level = 8'd5;
    start_dec  = 1'b1;
    @(negedge clk);
    start_dec  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bin_valid = 1'b1;
      bin_val   = (i < 3) || (i == 4);
      @(negedge clk);
      bin_valid = 1'b0;
    end
    chk("c6_mid_ready", 32'(bin_ready), 32'd1);
    chk("c6_mid_done", 32'(dec_done), 32'd0);
    chk("c6_mid_bins", 32'(num_bins), 32'd6);
    chk("c6_mid_err", 32'(dec_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("c6_rst_ready", 32'(bin_ready), 32'd0);
    chk("c6_rst_done", 32'(dec_done), 32'd0);
    chk("c6_rst_bins", 32'(num_bins), 32'd0);
    chk("c6_rst_symbol", symbol, 32'd0);
    chk("c6_rst_abs", abs_level, 32'd0);
    chk("c6_rst_err", 32'(dec_err), 32'd0);
    // Leftover bins after reset must not be consumed while IDLE
    bin_valid = 1'b1;
    bin_val   = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    chk("c6_idle_bins", 32'(num_bins), 32'd0);

    decode(3'd1, 8'd1, 32'b1101, 4, 0);
    chk("c6_fresh_symbol", symbol, 32'd5);
    chk("c6_fresh_abs", abs_level, 32'd6);
    chk("c6_fresh_bins", 32'(num_bins), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
